alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-cycle ALU.
- Stage 1 evaluates the arithmetic/logic operation; stage 2 applies the shift and generates the status flags.
- Valid/ready handshakes on both sides let the block sit between an operand-fetch unit and a writeback unit that may stall.
- Data width is configurable, and the block adds Z/N/C/V flags.

---
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 evaluates the op, stage 2 shifts and
// builds Z/N/C/V, with valid/ready handshakes on both sides.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       opcode_i,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags_o
);

    localparam int M = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic [1:0]       sh;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [3:0]       flags;
    } s2_t;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;
    logic s1_adv, s2_adv;

    logic [WIDTH:0] sum, diff;

    always_comb begin
        s2_adv = !s2_valid_q || out_ready_i;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_valid_q;
    assign alu_out     = s2_q.res;
    assign flags_o     = s2_q.flags;

    // Subtraction shares the adder form A + ~B + 1 so C reads as "no borrow".
    always_comb begin
        sum  = {1'b0, input_a} + {1'b0, input_b};
        diff = {1'b0, input_a} + {1'b0, ~input_b} + (WIDTH + 1)'(1);
    end

    always_comb begin
        s1_new     = '0;
        s1_new.sh  = opcode_i[4:3];
        unique case (opcode_i[2:0])
            3'd0: s1_new.res = input_a;
            3'd1: begin
                s1_new.res = sum[M:0];
                s1_new.c   = sum[WIDTH];
                s1_new.v   = (input_a[M] == input_b[M]) &&
                             (sum[M] != input_a[M]);
            end
            3'd2: begin
                s1_new.res = diff[M:0];
                s1_new.c   = diff[WIDTH];
                s1_new.v   = (input_a[M] != input_b[M]) &&
                             (diff[M] != input_a[M]);
            end
            3'd3: s1_new.res = input_a & input_b;
            3'd4: s1_new.res = input_a | input_b;
            3'd5: s1_new.res = input_a ^ input_b;
            3'd6: s1_new.res = input_b;
            3'd7: s1_new.res = ~input_a;
        endcase
    end

    logic [WIDTH-1:0] sh_res;
    logic             sh_c;

    always_comb begin
        sh_res = s1_q.res;
        sh_c   = s1_q.c;
        unique case (s1_q.sh)
            2'd0: ;
            2'd1: {sh_c, sh_res} = {s1_q.res, 1'b0};
            2'd2: {sh_res, sh_c} = {1'b0, s1_q.res};
            2'd3: {sh_res, sh_c} = {s1_q.res[M], s1_q.res};
        endcase
        s2_new.res   = sh_res;
        s2_new.flags = {sh_res == '0, sh_res[M], sh_c, s1_q.v};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s1_adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) s1_d = s1_new;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_d = s2_new;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, backpressure, streaming and
// randomized traffic against a plain-arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv = 0, ir, ov, ordy = 1;
    logic [4:0]  opc = 0;
    logic [31:0] a = 0, b = 0, y;
    logic [3:0]  fl;

    logic        iv8 = 0, ir8, ov8, ordy8 = 1;
    logic [4:0]  opc8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, y8;
    logic [3:0]  fl8;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .in_valid_i(iv), .in_ready_o(ir), .opcode_i(opc),
        .input_a(a), .input_b(b),
        .out_valid_o(ov), .out_ready_i(ordy),
        .alu_out(y), .flags_o(fl)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clock_i(clk), .reset_n_i(rst_n),
        .in_valid_i(iv8), .in_ready_o(ir8), .opcode_i(opc8),
        .input_a(a8), .input_b(b8),
        .out_valid_o(ov8), .out_ready_i(ordy8),
        .alu_out(y8), .flags_o(fl8)
    );

    // Reference: {result[31:0], Z, N, C, V} from integer arithmetic.
    function automatic logic [35:0] model(input int w, input logic [4:0] o,
                                          input logic [31:0] ia,
                                          input logic [31:0] ib);
        longint full, mask, half, ua, ub, sa, sb, r, t;
        logic   c, v;
        full = longint'(1) << w;
        mask = full - 1;
        half = full >> 1;
        ua = {32'd0, ia} & mask;
        ub = {32'd0, ib} & mask;
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        c = 0;
        v = 0;
        r = 0;
        case (o[2:0])
            3'd0: r = ua;
            3'd1: begin
                r = ua + ub;
                c = (r >= full);
                t = sa + sb;
                v = (t >= half) || (t < -half);
                r = r & mask;
            end
            3'd2: begin
                r = ua + ((~ub) & mask) + 1;
                c = (r >= full);
                t = sa - sb;
                v = (t >= half) || (t < -half);
                r = r & mask;
            end
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = ub;
            default: r = (~ua) & mask;
        endcase
        case (o[4:3])
            2'd1: begin c = (r >= half); r = (r << 1) & mask; end
            2'd2: begin c = (r & 1) != 0; r = r >> 1; end
            2'd3: begin c = (r & 1) != 0; r = (r >> 1) | (r & half); end
            default: ;
        endcase
        return {r[31:0], r == 0, r >= half, c, v};
    endfunction

    task automatic cycle(input logic v, input logic [4:0] o,
                         input logic [31:0] ia, input logic [31:0] ib,
                         input logic r,
                         output logic sir, output logic sov,
                         output logic [31:0] sy, output logic [3:0] sfl);
        @(negedge clk);
        iv = v; opc = o; a = ia; b = ib; ordy = r;
        #1;
        sir = ir; sov = ov; sy = y; sfl = fl;
    endtask

    logic [4:0]  d_op [6] = '{5'h01, 5'h02, 5'h02, 5'h18, 5'h08, 5'h10};
    logic [31:0] d_a  [6] = '{32'h44e96cb8, 32'h5, 32'h0,
                              32'h80000000, 32'h80000001, 32'h3};
    logic [31:0] d_b  [6] = '{32'h79adc30e, 32'h5, 32'h1, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_y  [6] = '{32'hBE972FC6, 32'h0, 32'hFFFFFFFF,
                              32'hC0000000, 32'h2, 32'h1};
    logic [3:0]  d_f  [6] = '{4'b0101, 4'b1010, 4'b0100,
                              4'b0100, 4'b0010, 4'b0010};

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (ov !== 1'b0) begin
            n_err++; $display("FAIL reset_ovalid got %b want 0", ov);
        end
        n_vec++;
        if (y !== 32'h0) begin
            n_err++; $display("FAIL reset_out got %h want 0", y);
        end
        n_vec++;
        if (fl !== 4'h0) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", fl);
        end
        rst_n = 1;
        #1;
        n_vec++;
        if (ir !== 1'b1) begin
            n_err++; $display("FAIL reset_iready got %b want 1", ir);
        end
    endtask

    task automatic test_directed;
        logic sir, sov;
        logic [31:0] sy;
        logic [3:0] sfl;
        int lat;
        for (int i = 0; i < 6; i++) begin
            cycle(1, d_op[i], d_a[i], d_b[i], 1, sir, sov, sy, sfl);
            n_vec++;
            if (sir !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_accept got %b want 1", i, sir);
            end
            lat = 0;
            for (int k = 1; k <= 6 && lat == 0; k++) begin
                cycle(0, 0, 0, 0, 1, sir, sov, sy, sfl);
                if (sov === 1'b1) lat = k;
            end
            n_vec++;
            if (lat != 2) begin
                n_err++; $display("FAIL dir%0d_latency got %0d want 2", i, lat);
            end
            n_vec++;
            if (sy !== d_y[i]) begin
                n_err++; $display("FAIL dir%0d_out got %h want %h", i, sy, d_y[i]);
            end
            n_vec++;
            if (sfl !== d_f[i]) begin
                n_err++; $display("FAIL dir%0d_flags got %b want %b", i, sfl, d_f[i]);
            end
        end
    endtask

    task automatic test_width8;
        logic [7:0] va [2] = '{8'hFF, 8'h7F};
        logic [7:0] ey [2] = '{8'h00, 8'h80};
        logic [3:0] ef [2] = '{4'b1010, 4'b0101};
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            iv8 = 1; opc8 = 5'h01; a8 = va[i]; b8 = 8'h01; ordy8 = 1;
            lat = 0;
            for (int k = 1; k <= 6 && lat == 0; k++) begin
                @(negedge clk);
                iv8 = 0;
                #1;
                if (ov8 === 1'b1) lat = k;
            end
            n_vec++;
            if (lat != 2) begin
                n_err++; $display("FAIL w8_%0d_latency got %0d want 2", i, lat);
            end
            n_vec++;
            if (y8 !== ey[i]) begin
                n_err++; $display("FAIL w8_%0d_out got %h want %h", i, y8, ey[i]);
            end
            n_vec++;
            if (fl8 !== ef[i]) begin
                n_err++; $display("FAIL w8_%0d_flags got %b want %b", i, fl8, ef[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic sir, sov;
        logic [31:0] sy;
        logic [3:0] sfl;
        logic pend;
        logic [31:0] got [$];
        cycle(1, 5'h01, 1, 1, 0, sir, sov, sy, sfl);
        n_vec++;
        if (sir !== 1'b1) begin
            n_err++; $display("FAIL bp_accept1 got %b want 1", sir);
        end
        cycle(1, 5'h01, 2, 2, 0, sir, sov, sy, sfl);
        n_vec++;
        if (sir !== 1'b1) begin
            n_err++; $display("FAIL bp_accept2 got %b want 1", sir);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 5'h01, 3, 3, 0, sir, sov, sy, sfl);
            n_vec++;
            if (sir !== 1'b0 || sov !== 1'b1 || sy !== 32'h2) begin
                n_err++;
                $display("FAIL bp_hold%0d got ir=%b ov=%b out=%h want ir=0 ov=1 out=2",
                         k, sir, sov, sy);
            end
        end
        pend = 1;
        for (int k = 0; k < 12; k++) begin
            cycle(pend, 5'h01, 3, 3, 1, sir, sov, sy, sfl);
            if (k == 0) begin
                n_vec++;
                if (sir !== 1'b1 || sov !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_simul got ir=%b ov=%b want 1 1", sir, sov);
                end
            end
            if (pend && sir) pend = 0;
            if (sov === 1'b1) got.push_back(sy);
        end
        n_vec++;
        if (got.size() != 3) begin
            n_err++; $display("FAIL bp_count got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got[i] !== 32'(2 * (i + 1))) begin
                    n_err++;
                    $display("FAIL bp_order%0d got %h want %h", i, got[i], 2 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_stream;
        logic sir, sov;
        logic [31:0] sy, ra, rb;
        logic [3:0] sfl;
        logic [4:0] ro;
        logic [35:0] exp_q [$];
        logic [35:0] e;
        int in_slot;
        for (int i = 0; i < 104; i++) begin
            ro = 5'($urandom); ra = $urandom; rb = $urandom;
            cycle(i < 100, ro, ra, rb, 1, sir, sov, sy, sfl);
            if (i < 100) begin
                n_vec++;
                if (sir !== 1'b1) begin
                    n_err++; $display("FAIL stream_iready%0d got %b want 1", i, sir);
                end
                exp_q.push_back(model(32, ro, ra, rb));
            end
            in_slot = (i >= 2 && i <= 101) ? 1 : 0;
            n_vec++;
            if (sov !== 1'(in_slot)) begin
                n_err++;
                $display("FAIL stream_ovalid%0d got %b want %0d", i, sov, in_slot);
            end
            if (sov === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({sy, sfl} !== e) begin
                    n_err++;
                    $display("FAIL stream_data%0d got %h/%b want %h/%b",
                             i, sy, sfl, e[35:4], e[3:0]);
                end
            end
        end
    endtask

    task automatic test_random_bp;
        logic sir, sov, v, r, hold;
        logic [31:0] sy, ra, rb, py;
        logic [3:0] sfl, pfl, ro4;
        logic [4:0] ro;
        logic [35:0] exp_q [$];
        logic [35:0] e;
        hold = 0; py = 0; pfl = 0;
        for (int i = 0; i < 310; i++) begin
            v = (i < 300) && ($urandom_range(9) < 7);
            r = (i >= 300) || ($urandom_range(9) < 6);
            ro = 5'($urandom); ra = $urandom; rb = $urandom;
            cycle(v, ro, ra, rb, r, sir, sov, sy, sfl);
            if (hold) begin
                n_vec++;
                if (sov !== 1'b1 || sy !== py || sfl !== pfl) begin
                    n_err++;
                    $display("FAIL rbp_stable%0d got %b %h %b want 1 %h %b",
                             i, sov, sy, sfl, py, pfl);
                end
            end
            if (v && sir) exp_q.push_back(model(32, ro, ra, rb));
            if (sov === 1'b1 && r) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rbp_extra%0d got %h want none", i, sy);
                end else begin
                    e = exp_q.pop_front();
                    if ({sy, sfl} !== e) begin
                        n_err++;
                        $display("FAIL rbp_data%0d got %h/%b want %h/%b",
                                 i, sy, sfl, e[35:4], e[3:0]);
                    end
                end
            end
            hold = (sov === 1'b1) && !r;
            py = sy; pfl = sfl;
        end
        ro4 = 4'(exp_q.size());
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rbp_lost got %0d left want 0", ro4);
        end
    endtask

    task automatic test_reset_mid;
        logic sir, sov;
        logic [31:0] sy;
        logic [3:0] sfl;
        int lat;
        cycle(1, 5'h01, 10, 20, 1, sir, sov, sy, sfl);
        cycle(1, 5'h02, 9, 30, 1, sir, sov, sy, sfl);
        @(negedge clk);
        iv = 0;
        #1;
        n_vec++;
        if (ov !== 1'b1) begin
            n_err++; $display("FAIL rmid_inflight got %b want 1", ov);
        end
        rst_n = 0;
        #1;
        n_vec++;
        if (ov !== 1'b0 || fl !== 4'h0) begin
            n_err++; $display("FAIL rmid_clear got ov=%b fl=%b want 0 0000", ov, fl);
        end
        #1;
        rst_n = 1;
        #1;
        n_vec++;
        if (ir !== 1'b1) begin
            n_err++; $display("FAIL rmid_iready got %b want 1", ir);
        end
        cycle(1, 5'h01, 7, 8, 1, sir, sov, sy, sfl);
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            cycle(0, 0, 0, 0, 1, sir, sov, sy, sfl);
            if (sov === 1'b1) lat = k;
        end
        n_vec++;
        if (lat != 2 || sy !== 32'd15 || sfl !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_next got lat=%0d out=%h fl=%b want 2 0000000f 0000",
                     lat, sy, sfl);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_width8();
        test_backpressure();
        test_stream();
        test_random_bp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
